// File: rtl/resta_bcd_display.sv
// Display stage for the N-bit subtractor: latches magnitude and sign on start,
// converts to BCD with shift-add-3 (one bit per clock) and drives active-low 7-segment digits.
module resta_bcd_display #(
    parameter int BITS   = 4,
    parameter int DIGITS = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [BITS-1:0]       mag,
    input  logic                  carry,
    output logic                  busy,
    output logic                  done,
    output logic                  neg,
    output logic [4*DIGITS-1:0]   bcd,
    output logic [7*DIGITS-1:0]   seg,
    output logic [6:0]            seg_sign
);

    localparam int CW = $clog2(BITS + 1);
    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_MINUS = 7'b0111111;

    function automatic logic [127:0] pow10(input int n);
        logic [127:0] r;
        r = 128'd1;
        for (int k = 0; k < n; k++) begin
            r = r * 128'd10;
        end
        return r;
    endfunction

    localparam logic [127:0] DEC_RANGE = pow10(DIGITS);
    localparam logic [127:0] MAX_MAG   = (128'd1 << BITS) - 128'd1;

    // Refuse to elaborate a configuration whose largest magnitude does not fit in DIGITS digits.
    generate
        if (DEC_RANGE <= MAX_MAG) begin : g_range_check
            $error("resta_bcd_display: DIGITS too small for BITS");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        LOAD
    } state_t;

    state_t                 state_q, state_d;
    logic [BITS-1:0]        shreg_q, shreg_d;
    logic [4*DIGITS-1:0]    acc_q, acc_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic                   negCap_q, negCap_d;
    logic [4*DIGITS-1:0]    bcd_q, bcd_d;
    logic [7*DIGITS-1:0]    seg_q, seg_d;
    logic                   neg_q, neg_d;
    logic [6:0]             sign_q, sign_d;
    logic                   done_q, done_d;

    logic [4*DIGITS-1:0]    accAdj;
    logic [7*DIGITS-1:0]    segNext;
    logic [3:0]             digit;
    logic                   seenNonZero;

    function automatic logic [6:0] seg7(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'b1000000;
            4'd1:    s = 7'b1111001;
            4'd2:    s = 7'b0100100;
            4'd3:    s = 7'b0110000;
            4'd4:    s = 7'b0011001;
            4'd5:    s = 7'b0010010;
            4'd6:    s = 7'b0000010;
            4'd7:    s = 7'b1111000;
            4'd8:    s = 7'b0000000;
            4'd9:    s = 7'b0010000;
            default: s = 7'b1111111;
        endcase
        return s;
    endfunction

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            shreg_q  <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            negCap_q <= 1'b0;
            bcd_q    <= '0;
            seg_q    <= '1;
            neg_q    <= 1'b0;
            sign_q   <= SEG_BLANK;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            shreg_q  <= shreg_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            negCap_q <= negCap_d;
            bcd_q    <= bcd_d;
            seg_q    <= seg_d;
            neg_q    <= neg_d;
            sign_q   <= sign_d;
            done_q   <= done_d;
        end
    end

    // Digit correction before each shift, and segment encoding with leading-zero blanking.
    always_comb begin
        accAdj      = acc_q;
        segNext     = '1;
        digit       = 4'd0;
        seenNonZero = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            if (acc_q[4*i +: 4] >= 4'd5) begin
                accAdj[4*i +: 4] = acc_q[4*i +: 4] + 4'd3;
            end
        end
        for (int i = DIGITS - 1; i >= 0; i--) begin
            digit = acc_q[4*i +: 4];
            if (digit != 4'd0) begin
                seenNonZero = 1'b1;
            end
            if (seenNonZero || (i == 0)) begin
                segNext[7*i +: 7] = seg7(digit);
            end else begin
                segNext[7*i +: 7] = SEG_BLANK;
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        shreg_d  = shreg_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        negCap_d = negCap_q;
        bcd_d    = bcd_q;
        seg_d    = seg_q;
        neg_d    = neg_q;
        sign_d   = sign_q;
        done_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    shreg_d  = mag;
                    negCap_d = ~carry & (mag != '0);
                    acc_d    = '0;
                    cnt_d    = CW'(BITS);
                    state_d  = SHIFT;
                end
            end
            SHIFT: begin
                acc_d   = {accAdj[4*DIGITS-2:0], shreg_q[BITS-1]};
                shreg_d = shreg_q << 1;
                cnt_d   = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    state_d = LOAD;
                end
            end
            LOAD: begin
                bcd_d   = acc_q;
                seg_d   = segNext;
                neg_d   = negCap_q;
                sign_d  = negCap_q ? SEG_MINUS : SEG_BLANK;
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign busy     = (state_q != IDLE);
    assign done     = done_q;
    assign neg      = neg_q;
    assign bcd      = bcd_q;
    assign seg      = seg_q;
    assign seg_sign = sign_q;

endmodule

// File: tb/tb_resta_bcd_display.sv
// Scoreboard bench for resta_bcd_display: a 4-bit/2-digit and an 8-bit/3-digit instance,
// expected results queued at stimulus time and checked whenever done pulses.
module tb_resta_bcd_display;

    localparam logic [6:0] S0 = 7'b1000000;
    localparam logic [6:0] S1 = 7'b1111001;
    localparam logic [6:0] S2 = 7'b0100100;
    localparam logic [6:0] S5 = 7'b0010010;
    localparam logic [6:0] S7 = 7'b1111000;
    localparam logic [6:0] S9 = 7'b0010000;
    localparam logic [6:0] SB = 7'b1111111;
    localparam logic [6:0] SM = 7'b0111111;

    typedef struct packed {
        logic [11:0] bcd;
        logic [20:0] seg;
        logic        neg;
        logic [6:0]  sgn;
        logic [31:0] cyc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start4 = 1'b0, carry4 = 1'b0;
    logic [3:0]  mag4 = '0;
    logic        busy4, done4, neg4;
    logic [7:0]  bcd4;
    logic [13:0] seg4;
    logic [6:0]  sign4;
    logic        start8 = 1'b0, carry8 = 1'b0;
    logic [7:0]  mag8 = '0;
    logic        busy8, done8, neg8;
    logic [11:0] bcd8;
    logic [20:0] seg8;
    logic [6:0]  sign8;

    int   checks = 0;
    int   errors = 0;
    int   cycle = 0;
    int   busyRun = 0;
    int   lastBusyRun = 0;
    exp_t q4[$];
    exp_t q8[$];
    exp_t e4, e8;

    resta_bcd_display #(.BITS(4), .DIGITS(2)) dut4 (
        .clk(clk), .rst(rst), .start(start4), .mag(mag4), .carry(carry4),
        .busy(busy4), .done(done4), .neg(neg4), .bcd(bcd4), .seg(seg4), .seg_sign(sign4)
    );

    resta_bcd_display #(.BITS(8), .DIGITS(3)) dut8 (
        .clk(clk), .rst(rst), .start(start8), .mag(mag8), .carry(carry8),
        .busy(busy8), .done(done8), .neg(neg8), .bcd(bcd8), .seg(seg8), .seg_sign(sign8)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cycle <= cycle + 1;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: actual %0h required %0h", name, act, exp);
        end
    endtask

    // Track the length of each busy run on the 4-bit instance.
    always @(negedge clk) begin
        if (busy4) begin
            busyRun <= busyRun + 1;
        end else if (busyRun != 0) begin
            lastBusyRun <= busyRun;
            busyRun <= 0;
        end
    end

    always @(negedge clk) begin
        if (rst && done4) begin
            if (q4.size() == 0) begin
                checkOutput("unexpected_done4", 32'd1, 32'd0);
            end else begin
                e4 = q4.pop_front();
                checkOutput("done4_cycle", cycle, e4.cyc);
                checkOutput("bcd4", {24'd0, bcd4}, {20'd0, e4.bcd});
                checkOutput("seg4", {18'd0, seg4}, {11'd0, e4.seg});
                checkOutput("neg4", {31'd0, neg4}, {31'd0, e4.neg});
                checkOutput("sign4", {25'd0, sign4}, {25'd0, e4.sgn});
                checkOutput("busy4_at_done", {31'd0, busy4}, 32'd0);
            end
        end
    end

    always @(negedge clk) begin
        if (rst && done8) begin
            if (q8.size() == 0) begin
                checkOutput("unexpected_done8", 32'd1, 32'd0);
            end else begin
                e8 = q8.pop_front();
                checkOutput("done8_cycle", cycle, e8.cyc);
                checkOutput("bcd8", {20'd0, bcd8}, {20'd0, e8.bcd});
                checkOutput("seg8", {11'd0, seg8}, {11'd0, e8.seg});
                checkOutput("neg8", {31'd0, neg8}, {31'd0, e8.neg});
                checkOutput("sign8", {25'd0, sign8}, {25'd0, e8.sgn});
            end
        end
    end

    task automatic applyStimulus4(input logic [3:0] m, input logic c, input logic [7:0] eb,
                                  input logic [13:0] es, input logic en, input logic doPush);
        exp_t e;
        @(negedge clk);
        mag4 = m;
        carry4 = c;
        start4 = 1'b1;
        if (doPush) begin
            e.bcd = {4'd0, eb};
            e.seg = {7'd0, es};
            e.neg = en;
            e.sgn = en ? SM : SB;
            e.cyc = cycle + 1 + 5;
            q4.push_back(e);
        end
        @(negedge clk);
        start4 = 1'b0;
        mag4 = ~m;
        carry4 = ~c;
    endtask

    task automatic applyStimulus8(input logic [7:0] m, input logic c, input logic [11:0] eb,
                                  input logic [20:0] es, input logic en);
        exp_t e;
        @(negedge clk);
        mag8 = m;
        carry8 = c;
        start8 = 1'b1;
        e.bcd = eb;
        e.seg = es;
        e.neg = en;
        e.sgn = en ? SM : SB;
        e.cyc = cycle + 1 + 9;
        q8.push_back(e);
        @(negedge clk);
        start8 = 1'b0;
        mag8 = ~m;
        carry8 = ~c;
    endtask

    task automatic waitIdle(input string name);
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (q4.size() == 0 && q8.size() == 0 && !busy4 && !busy8) break;
        end
        @(negedge clk);
        checkOutput(name, q4.size() + q8.size(), 32'd0);
    endtask

    task automatic checkReset4(input string tag);
        checkOutput({tag, "_busy"}, {31'd0, busy4}, 32'd0);
        checkOutput({tag, "_done"}, {31'd0, done4}, 32'd0);
        checkOutput({tag, "_neg"}, {31'd0, neg4}, 32'd0);
        checkOutput({tag, "_bcd"}, {24'd0, bcd4}, 32'd0);
        checkOutput({tag, "_seg"}, {18'd0, seg4}, 32'h3FFF);
        checkOutput({tag, "_sign"}, {25'd0, sign4}, {25'd0, SB});
    endtask

    initial begin
        #12;
        checkReset4("reset4");
        checkOutput("reset8_seg", {11'd0, seg8}, 32'h1FFFFF);
        checkOutput("reset8_bcd", {20'd0, bcd8}, 32'd0);
        @(negedge clk);
        rst = 1'b1;

        applyStimulus4(4'd9, 1'b1, 8'h09, {SB, S9}, 1'b0, 1'b1);
        waitIdle("drain_9");
        applyStimulus4(4'd15, 1'b0, 8'h15, {S1, S5}, 1'b1, 1'b1);
        waitIdle("drain_15");
        applyStimulus4(4'd0, 1'b0, 8'h00, {SB, S0}, 1'b0, 1'b1);
        waitIdle("drain_0");
        applyStimulus4(4'd5, 1'b0, 8'h05, {SB, S5}, 1'b1, 1'b1);
        waitIdle("drain_5");

        // Second start while busy must be dropped; only the 12 comes out.
        applyStimulus4(4'd12, 1'b1, 8'h12, {S1, S2}, 1'b0, 1'b1);
        applyStimulus4(4'd3, 1'b1, 8'h03, {SB, 7'b0110000}, 1'b0, 1'b0);
        waitIdle("drain_12");
        checkOutput("busy_run_len", lastBusyRun, 32'd5);

        // Abort a conversion of 7 with reset; no done may follow.
        applyStimulus4(4'd7, 1'b1, 8'h07, {SB, S7}, 1'b0, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        checkReset4("abort4");
        repeat (2) @(negedge clk);
        rst = 1'b1;
        repeat (8) @(negedge clk);
        checkOutput("abort_no_done_bcd", {24'd0, bcd4}, 32'd0);
        applyStimulus4(4'd7, 1'b1, 8'h07, {SB, S7}, 1'b0, 1'b1);
        waitIdle("drain_7");

        applyStimulus8(8'd255, 1'b0, 12'h255, {S2, S5, S5}, 1'b1);
        waitIdle("drain_255");
        applyStimulus8(8'd100, 1'b1, 12'h100, {S1, S0, S0}, 1'b0);
        waitIdle("drain_100");
        applyStimulus8(8'd5, 1'b1, 12'h005, {SB, SB, S5}, 1'b0);
        waitIdle("drain_5_8");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
